// File: rtl/code_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : code_loader_pkg
//  Brief    : Shared CPU constants (code memory geometry) and the program
//             loader's state encoding and stream-protocol helpers.
//  Revision : 1.0 - initial release
// ============================================================================
package code_loader_pkg;

    // Code memory geometry, shared with the code memory and the PC
    localparam int CODE_ADDR_W = 6;
    localparam int CODE_DEPTH  = 64;
    localparam int CODE_WORD_W = 16;

    // Stream protocol: length byte, then each word high byte first, then an
    // XOR checksum over every preceding byte (seeded with the length byte).
    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN   = 3'd1,
        S_HI    = 3'd2,
        S_LO    = 3'd3,
        S_WRITE = 3'd4,
        S_CSUM  = 3'd5,
        S_DONE  = 3'd6,
        S_ERR   = 3'd7
    } loader_state_t;

    // Running checksum update for one accepted stream byte
    function automatic logic [BYTE_W-1:0] csum_step(input logic [BYTE_W-1:0] acc,
                                                    input logic [BYTE_W-1:0] b);
        return acc ^ b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/code_loader_timeout.sv
`default_nettype none
// ============================================================================
//  Module   : loader_timeout
//  Brief    : Idle-cycle counter for the program loader. Counts while enabled
//             and not cleared; flags expiry on the cycle the count would reach
//             TIMEOUT_CYCLES. A TIMEOUT_CYCLES of 0 disables expiry.
//  Revision : 1.0 - initial release
// ============================================================================
module loader_timeout #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_disabled
            logic w_unused;
            assign w_unused = &{1'b0, clock, reset, clear, enable};
            assign expired  = 1'b0;
        end else begin : g_enabled
            localparam logic [CNT_W-1:0] c_limit = CNT_W'(TIMEOUT_CYCLES - 1);
            logic [CNT_W-1:0] r_count;

            // Idle counter: restarts on any accepted byte or outside waiting states
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    r_count <= '0;
                end else if (clear || !enable) begin
                    r_count <= '0;
                end else begin
                    r_count <= r_count + 1'b1;
                end
            end

            // Expiry fires on the cycle whose edge completes the idle budget
            assign expired = enable && !clear && (r_count == c_limit);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/code_loader.sv
`default_nettype none
// ============================================================================
//  Module   : code_loader
//  Brief    : Byte-stream program loader feeding the code memory write port.
//             Assembles 16-bit words (high byte first), writes them one per
//             WRITE cycle, validates an XOR checksum and holds the CPU (busy)
//             for the duration of the load.
//  Revision : 1.0 - initial release
// ============================================================================
module code_loader
    import code_loader_pkg::*;
#(
    parameter int ADDR_W         = CODE_ADDR_W,
    parameter int DEPTH          = CODE_DEPTH,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   byte_valid,
    input  logic [BYTE_W-1:0]      byte_data,
    output logic                   byte_ready,
    output logic                   c1,
    output logic [ADDR_W-1:0]      write_select,
    output logic [CODE_WORD_W-1:0] inp,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [ADDR_W:0]        words_written
);

    loader_state_t     r_state;
    logic [BYTE_W-1:0] r_csum;
    logic [ADDR_W:0]   r_len;

    logic              w_accept;
    logic              w_tmo_en;
    logic              w_expired;
    logic              w_len_bad;
    logic [ADDR_W:0]   w_words_next;

    assign w_accept     = byte_valid && byte_ready;
    assign w_tmo_en     = (r_state == S_HI) || (r_state == S_LO) || (r_state == S_CSUM);
    assign w_len_bad    = (byte_data == '0) || ({24'd0, byte_data} > 32'(DEPTH));
    assign w_words_next = words_written + 1'b1;

    loader_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clock   (clock),
        .reset   (reset),
        .clear   (w_accept),
        .enable  (w_tmo_en),
        .expired (w_expired)
    );

    // Load sequencer with all outputs registered alongside the state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_csum        <= '0;
            r_len         <= '0;
            byte_ready    <= 1'b0;
            c1            <= 1'b0;
            write_select  <= '0;
            inp           <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            words_written <= '0;
        end else begin
            c1 <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        done          <= 1'b0;
                        error         <= 1'b0;
                        words_written <= '0;
                        r_csum        <= '0;
                        write_select  <= '0;
                        busy          <= 1'b1;
                        byte_ready    <= 1'b1;
                        r_state       <= S_LEN;
                    end
                end
                S_LEN: begin
                    if (w_accept) begin
                        r_csum <= byte_data;
                        if (w_len_bad) begin
                            byte_ready <= 1'b0;
                            busy       <= 1'b0;
                            error      <= 1'b1;
                            r_state    <= S_ERR;
                        end else begin
                            r_len   <= (ADDR_W+1)'(byte_data);
                            r_state <= S_HI;
                        end
                    end
                end
                S_HI: begin
                    if (w_accept) begin
                        inp[CODE_WORD_W-1:BYTE_W] <= byte_data;
                        r_csum                    <= csum_step(r_csum, byte_data);
                        r_state                   <= S_LO;
                    end else if (w_expired) begin
                        byte_ready <= 1'b0;
                        busy       <= 1'b0;
                        error      <= 1'b1;
                        r_state    <= S_ERR;
                    end
                end
                S_LO: begin
                    if (w_accept) begin
                        inp[BYTE_W-1:0] <= byte_data;
                        r_csum          <= csum_step(r_csum, byte_data);
                        byte_ready      <= 1'b0;
                        c1              <= 1'b1;
                        r_state         <= S_WRITE;
                    end else if (w_expired) begin
                        byte_ready <= 1'b0;
                        busy       <= 1'b0;
                        error      <= 1'b1;
                        r_state    <= S_ERR;
                    end
                end
                S_WRITE: begin
                    write_select  <= write_select + 1'b1;
                    words_written <= w_words_next;
                    byte_ready    <= 1'b1;
                    r_state       <= (w_words_next == r_len) ? S_CSUM : S_HI;
                end
                S_CSUM: begin
                    if (w_accept) begin
                        byte_ready <= 1'b0;
                        busy       <= 1'b0;
                        if (byte_data == r_csum) begin
                            done    <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            error   <= 1'b1;
                            r_state <= S_ERR;
                        end
                    end else if (w_expired) begin
                        byte_ready <= 1'b0;
                        busy       <= 1'b0;
                        error      <= 1'b1;
                        r_state    <= S_ERR;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                S_ERR:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
